// File: rtl/div_ctrl_pkg.sv
// Shared types for the divider issue/retire controller.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DRAINED
  } div_state_t;

  typedef struct packed {
    logic guard;
    logic round;
    logic sticky;
    logic count;
  } div_flags_t;

  // Core latency in cycles equals its internal register stage count.
  function automatic int unsigned div_lat(input int unsigned pipe_stages);
    return pipe_stages;
  endfunction

endpackage

// File: rtl/div_sig_issue_ctrl_valid_shift.sv
// LAT-deep valid/tag shadow of the divider core pipeline; a wire when LAT=0.
module div_valid_shift #(
  parameter int unsigned LAT   = 0,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_en,
  input  logic             i_vld,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_vld,
  output logic [TAG_W-1:0] o_tag
);

  if (LAT == 0) begin : g_pass
    logic w_unused;
    assign w_unused = &{1'b0, clk, resetn, i_en};
    assign o_vld    = i_vld;
    assign o_tag    = i_tag;
  end else begin : g_shift
    logic [LAT-1:0]   r_vld;
    logic [TAG_W-1:0] r_tag [LAT];

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_vld <= '0;
        for (int unsigned i = 0; i < LAT; i++) r_tag[i] <= '0;
      end else if (i_en) begin
        r_vld[0] <= i_vld;
        r_tag[0] <= i_tag;
        for (int unsigned i = 1; i < LAT; i++) begin
          r_vld[i] <= r_vld[i-1];
          r_tag[i] <= r_tag[i-1];
        end
      end
    end

    assign o_vld = r_vld[LAT-1];
    assign o_tag = r_tag[LAT-1];
  end

endmodule

// File: rtl/div_sig_issue_ctrl.sv
// Issue/retire controller for the pipelined radix-4 significand divider core:
// valid/ready on both sides, tag tracking, core stall and drain handshake.
module div_sig_issue_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned SIG_W       = 23,
  parameter int unsigned PIPE_STAGES = 0,
  parameter int unsigned TAG_W       = 4
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [SIG_W:0]                    in_x,
  input  logic [SIG_W:0]                    in_d,
  input  logic [TAG_W-1:0]                  in_tag,
  output logic [SIG_W:0]                    dp_x,
  output logic [SIG_W:0]                    dp_d,
  output logic                              dp_enable,
  input  logic [SIG_W:0]                    dp_quotient,
  input  logic                              dp_guard,
  input  logic                              dp_round,
  input  logic                              dp_sticky,
  input  logic                              dp_count,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [SIG_W:0]                    out_quotient,
  output logic                              out_guard,
  output logic                              out_round,
  output logic                              out_sticky,
  output logic                              out_count,
  output logic [TAG_W-1:0]                  out_tag,
  input  logic                              drain_req,
  output logic                              drain_done,
  output logic                              busy,
  output logic [$clog2(PIPE_STAGES+2)-1:0] occupancy
);

  localparam int unsigned LAT   = div_lat(PIPE_STAGES);
  localparam int unsigned OCC_W = $clog2(PIPE_STAGES + 2);

  typedef struct packed {
    logic [SIG_W:0]   quotient;
    div_flags_t       flags;
    logic [TAG_W-1:0] tag;
  } result_t;

  div_state_t       r_state;
  logic             r_live;
  logic             r_drain_done;
  logic             r_out_valid;
  result_t          r_res;
  logic [OCC_W-1:0] r_occ;

  logic             w_advance;
  logic             w_en;
  logic             w_accept;
  logic             w_retire;
  logic             w_head_vld;
  logic [TAG_W-1:0] w_head_tag;

  // r_live keeps in_ready and the core enable low until the first edge after reset.
  assign w_advance = !r_out_valid || out_ready;
  assign w_en      = w_advance && r_live;
  assign in_ready  = w_en && (r_state == RUN) && !drain_req;
  assign w_accept  = in_valid && in_ready;
  assign w_retire  = r_out_valid && out_ready;

  assign dp_x      = in_x;
  assign dp_d      = in_d;
  assign dp_enable = w_en;

  div_valid_shift #(
    .LAT   (LAT),
    .TAG_W (TAG_W)
  ) u_shift (
    .clk    (clk),
    .resetn (resetn),
    .i_en   (w_en),
    .i_vld  (w_accept),
    .i_tag  (in_tag),
    .o_vld  (w_head_vld),
    .o_tag  (w_head_tag)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_live      <= 1'b0;
      r_out_valid <= 1'b0;
      r_res       <= '0;
      r_occ       <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_en) begin
        r_out_valid <= w_head_vld;
        r_res       <= '{quotient: dp_quotient,
                         flags:    '{guard: dp_guard, round: dp_round,
                                     sticky: dp_sticky, count: dp_count},
                         tag:      w_head_tag};
      end
      if (w_accept && !w_retire)      r_occ <= r_occ + OCC_W'(1);
      else if (!w_accept && w_retire) r_occ <= r_occ - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= RUN;
      r_drain_done <= 1'b0;
    end else begin
      case (r_state)
        RUN: if (drain_req) r_state <= DRAIN;
        DRAIN: if (r_occ == '0) begin
          r_state      <= DRAINED;
          r_drain_done <= 1'b1;
        end
        DRAINED: if (!drain_req) begin
          r_state      <= RUN;
          r_drain_done <= 1'b0;
        end
        default: begin
          r_state      <= RUN;
          r_drain_done <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid    = r_out_valid;
  assign out_quotient = r_res.quotient;
  assign out_guard    = r_res.flags.guard;
  assign out_round    = r_res.flags.round;
  assign out_sticky   = r_res.flags.sticky;
  assign out_count    = r_res.flags.count;
  assign out_tag      = r_res.tag;
  assign drain_done   = r_drain_done;
  assign busy         = (r_occ != '0);
  assign occupancy    = r_occ;

endmodule

// File: tb/tb_div_sig_issue_ctrl.sv
// Directed bench for div_sig_issue_ctrl at PIPE_STAGES 0..3, each with a
// behavioural divider core stub.
module tb_div_sig_issue_ctrl;

  localparam int W  = 24;
  localparam int TW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                resetn;
  logic [W-1:0]        in_x, in_d;
  logic [TW-1:0]       in_tag;
  logic [3:0]          in_valid, out_ready, drain_req;
  logic [3:0]          in_ready, dp_en, out_valid, drain_done, busy;
  logic [3:0][W+3:0]   out_res;   // {quotient, guard, round, sticky, count}
  logic [3:0][TW-1:0]  out_tag;
  logic [3:0][2:0]     occ;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] expq[$];

  // Reference significand divide: 24 quotient bits plus guard/round/sticky, normalised.
  function automatic logic [W+3:0] ref_div(input logic [W-1:0] x, input logic [W-1:0] d);
    logic [W+26:0] num, q, rem;
    num = {x, 27'd0};
    q   = num / {27'd0, d};
    rem = num % {27'd0, d};
    if (q[27]) return {q[27:4], q[3], q[2], (|q[1:0]) | (rem != '0), 1'b0};
    else       return {q[26:3], q[2], q[1], q[0] | (rem != '0), 1'b1};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : inst
    localparam int OW = $clog2(g + 2);
    logic [W-1:0]  dp_x, dp_d, q_l;
    logic [W+3:0]  core_o;
    logic          g_l, r_l, s_l, c_l;
    logic [OW-1:0] occ_l;

    if (g == 0) begin : g_comb
      assign core_o = ref_div(dp_x, dp_d);
    end else begin : g_piped
      logic [W+3:0] pipe [g];
      always_ff @(posedge clk) begin
        if (dp_en[g]) begin
          pipe[0] <= ref_div(dp_x, dp_d);
          for (int k = 1; k < g; k++) pipe[k] <= pipe[k-1];
        end
      end
      assign core_o = pipe[g-1];
    end

    div_sig_issue_ctrl #(
      .SIG_W       (W - 1),
      .PIPE_STAGES (g),
      .TAG_W       (TW)
    ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .in_valid     (in_valid[g]),
      .in_ready     (in_ready[g]),
      .in_x         (in_x),
      .in_d         (in_d),
      .in_tag       (in_tag),
      .dp_x         (dp_x),
      .dp_d         (dp_d),
      .dp_enable    (dp_en[g]),
      .dp_quotient  (core_o[W+3:4]),
      .dp_guard     (core_o[3]),
      .dp_round     (core_o[2]),
      .dp_sticky    (core_o[1]),
      .dp_count     (core_o[0]),
      .out_valid    (out_valid[g]),
      .out_ready    (out_ready[g]),
      .out_quotient (q_l),
      .out_guard    (g_l),
      .out_round    (r_l),
      .out_sticky   (s_l),
      .out_count    (c_l),
      .out_tag      (out_tag[g]),
      .drain_req    (drain_req[g]),
      .drain_done   (drain_done[g]),
      .busy         (busy[g]),
      .occupancy    (occ_l)
    );

    assign out_res[g] = {q_l, g_l, r_l, s_l, c_l};
    assign occ[g]     = 3'(occ_l);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One isolated op: accept, then expect out_valid exactly lat+1 cycles later.
  task automatic issue_one(input int sel, input logic [W-1:0] x, input logic [W-1:0] d,
                           input logic [TW-1:0] tag, input int lat,
                           input logic [31:0] exp, input string name);
    @(negedge clk);
    in_x = x; in_d = d; in_tag = tag; in_valid[sel] = 1'b1;
    #1 check({name, "_accept"}, 32'(in_ready[sel]), 32'd1);
    for (int i = 1; i <= lat + 1; i++) begin
      @(negedge clk);
      if (i == 1) in_valid[sel] = 1'b0;
      check({name, "_latency"}, 32'(out_valid[sel]), 32'(i == lat + 1));
    end
    check({name, "_result"}, {out_res[sel], out_tag[sel]}, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int issued, retired, peak;
    logic stalled_prev, bad_occ, stale;
    logic [31:0] prev;

    resetn = 1'b0; in_valid = '0; out_ready = '1; drain_req = '0;
    in_x = 24'h800000; in_d = 24'h800000; in_tag = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_dp_enable", 32'(dp_en), 32'd0);
    check("rst_occupancy", 32'(occ), 32'd0);
    check("rst_out_data", 32'(out_res[3]), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1 check("in_ready_before_first_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("in_ready_after_release", 32'(in_ready), 32'hF);

    // Latency and data per depth
    issue_one(3, 24'hC00000, 24'h800000, 4'd5, 3, {24'hC00000, 4'b0000, 4'd5}, "t1_ps3");
    issue_one(2, 24'h800000, 24'hC00000, 4'd9, 2, {24'hAAAAAA, 4'b1011, 4'd9}, "t2_ps2");
    issue_one(1, 24'hA00000, 24'h800000, 4'd7, 1, {24'hA00000, 4'b0000, 4'd7}, "t2_ps1");
    issue_one(0, 24'hC00000, 24'h800000, 4'd3, 0, {24'hC00000, 4'b0000, 4'd3}, "t5_ps0");

    // Back-to-back ops with a 4-cycle output stall
    @(negedge clk);
    issued = 0; retired = 0; peak = 0; stalled_prev = 1'b0; prev = '0; expq.delete();
    for (int c = 0; c < 40 && retired < 6; c++) begin
      @(negedge clk);
      out_ready[3] = !(c >= 5 && c <= 8);
      if (issued < 6) begin
        in_valid[3] = 1'b1;
        in_x   = 24'h800000 + 24'(issued * 24'h0F1357);
        in_d   = 24'hFFFFFF - 24'(issued * 24'h111111);
        in_tag = 4'(issued);
      end else begin
        in_valid[3] = 1'b0;
      end
      #1;
      if (int'(occ[3]) > peak) peak = int'(occ[3]);
      if (out_valid[3] && !out_ready[3]) begin
        check("t3_stall_enable", 32'(dp_en[3]), 32'd0);
        check("t3_stall_in_ready", 32'(in_ready[3]), 32'd0);
        if (stalled_prev) check("t3_stall_stable", {out_res[3], out_tag[3]}, prev);
      end
      prev = {out_res[3], out_tag[3]};
      stalled_prev = out_valid[3] && !out_ready[3];
      if (out_valid[3] && out_ready[3]) begin
        if (expq.size() == 0) check("t3_extra_output", 32'd1, 32'd0);
        else                  check("t3_in_order", {out_res[3], out_tag[3]}, expq.pop_front());
        retired++;
      end
      if (in_valid[3] && in_ready[3]) begin
        expq.push_back({ref_div(in_x, in_d), in_tag});
        issued++;
      end
    end
    in_valid[3] = 1'b0; out_ready[3] = 1'b1;
    check("t3_retired", 32'(retired), 32'd6);
    check("t3_peak_occupancy", 32'(peak), 32'd4);

    // Drain with two ops in flight (PIPE_STAGES=1)
    @(negedge clk);
    in_x = 24'h900000; in_d = 24'h800000; in_tag = 4'd1; in_valid[1] = 1'b1;
    #1 check("t4_accept_a", 32'(in_ready[1]), 32'd1);
    @(negedge clk);
    in_tag = 4'd2;
    #1 check("t4_accept_b", 32'(in_ready[1]), 32'd1);
    @(negedge clk);
    in_valid[1] = 1'b0; drain_req[1] = 1'b1;
    #1;
    check("t4_in_ready_drop", 32'(in_ready[1]), 32'd0);
    check("t4_occ_two", 32'(occ[1]), 32'd2);
    check("t4_retire_a", {31'd0, out_valid[1]} << 4 | 32'(out_tag[1]), 32'h11);
    @(negedge clk);
    check("t4_retire_b", {31'd0, out_valid[1]} << 4 | 32'(out_tag[1]), 32'h12);
    check("t4_occ_one", 32'(occ[1]), 32'd1);
    check("t4_done_low_1", 32'(drain_done[1]), 32'd0);
    @(negedge clk);
    check("t4_empty", {occ[1], out_valid[1], drain_done[1]}, 32'd0);
    @(negedge clk);
    check("t4_drain_done", 32'(drain_done[1]), 32'd1);
    check("t4_ready_drained", 32'(in_ready[1]), 32'd0);
    @(negedge clk);
    drain_req[1] = 1'b0;
    #1 check("t4_ready_still_low", 32'(in_ready[1]), 32'd0);
    @(negedge clk);
    check("t4_ready_back", 32'(in_ready[1]), 32'd1);
    check("t4_done_cleared", 32'(drain_done[1]), 32'd0);

    // Random valid/ready traffic at PIPE_STAGES=0
    issued = 0; retired = 0; bad_occ = 1'b0; expq.delete();
    for (int c = 0; c < 20000 && retired < 1000; c++) begin
      @(negedge clk);
      if (issued < 1000) begin
        in_valid[0] = ($urandom_range(0, 3) != 0);
        in_x   = {1'b1, 23'($urandom)};
        in_d   = {1'b1, 23'($urandom)};
        in_tag = 4'($urandom);
      end else begin
        in_valid[0] = 1'b0;
      end
      out_ready[0] = ($urandom_range(0, 3) != 0);
      #1;
      if (occ[0] > 3'd1) bad_occ = 1'b1;
      if (out_valid[0] && out_ready[0]) begin
        if (expq.size() == 0) check("t5_extra_output", 32'd1, 32'd0);
        else                  check("t5_in_order", {out_res[0], out_tag[0]}, expq.pop_front());
        retired++;
      end
      if (in_valid[0] && in_ready[0]) begin
        expq.push_back({ref_div(in_x, in_d), in_tag});
        issued++;
      end
    end
    in_valid[0] = 1'b0; out_ready[0] = 1'b1;
    check("t5_retired", 32'(retired), 32'd1000);
    check("t5_leftover", 32'(expq.size()), 32'd0);
    check("t5_occ_bound", 32'(bad_occ), 32'd0);

    // Asynchronous reset with three ops in flight
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      in_x = 24'hE00000; in_d = 24'h900000; in_tag = 4'(k + 10); in_valid[3] = 1'b1;
      @(negedge clk);
    end
    in_valid[3] = 1'b0;
    @(negedge clk);
    #1;
    check("t6_pre_valid", 32'(out_valid[3]), 32'd1);
    check("t6_pre_occ", 32'(occ[3]), 32'd3);
    #1 resetn = 1'b0;
    #1;
    check("t6_async_valid", 32'(out_valid), 32'd0);
    check("t6_async_occ", 32'(occ), 32'd0);
    check("t6_async_busy", 32'(busy), 32'd0);
    check("t6_async_data", {out_res[3], out_tag[3]}, 32'd0);
    check("t6_async_ready", {in_ready, dp_en}, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid[3] || occ[3] != 3'd0) stale = 1'b1;
    end
    check("t6_no_stale_output", 32'(stale), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
